syscall_engine: RTL and testbench

- Multi-cycle syscall service unit beside the single-cycle MIPS core.
- Consumes the controller's syscall strobe plus $v0/$a0 and stalls the PC while servicing.
- Services: integer print, string print (fetched word-by-word from data memory), sbrk heap allocation with write-back to $v0, and exit.
- Streams console bytes out over a valid/ready byte interface.

---
 rtl/syscall_engine_if.sv | 37 +++
 rtl/syscall_engine.sv | 205 ++++++++++++++++++++
 tb/tb_syscall_engine.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/syscall_engine_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | syscall_engine_if : core-side bundle of the syscall service unit         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface syscall_engine_if;
  logic        syscall;
  logic [31:0] v0_data;
  logic [31:0] a0_data;
  logic        stall;
  logic        rf_we;
  logic [31:0] rf_wdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic [31:0] heap_ptr;
  logic        halted;
  logic        err_unsupported;

  // core / memory / console side
  modport master (
    output syscall, v0_data, a0_data, mem_rdata, out_ready,
    input  stall, rf_we, rf_wdata, mem_req, mem_addr, out_valid, out_data,
           heap_ptr, halted, err_unsupported
  );

  // engine side
  modport slave (
    input  syscall, v0_data, a0_data, mem_rdata, out_ready,
    output stall, rf_we, rf_wdata, mem_req, mem_addr, out_valid, out_data,
           heap_ptr, halted, err_unsupported
  );
endinterface
`default_nettype wire

// File: rtl/syscall_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | syscall_engine : multi-cycle syscall service (print int/str, sbrk, exit) |
// | Option macro: SYSCALL_PRINT_INT_EN enables the hex print-integer service |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module syscall_engine #(
  parameter logic [31:0] HEAP_BASE   = 32'h1000_0000,
  parameter logic [31:0] HEAP_BYTES  = 32'h0000_1000,
  parameter int          MAX_STR_LEN = 256
) (
  input  wire logic       clk,
  input  wire logic       reset,
  syscall_engine_if.slave bus
);
  localparam int                 c_CNT_W    = $clog2(MAX_STR_LEN + 1);
  localparam logic [c_CNT_W-1:0] c_LAST     = c_CNT_W'(MAX_STR_LEN - 1);
  localparam logic [33:0]        c_HEAP_END = {2'b00, HEAP_BASE} + {2'b00, HEAP_BYTES};

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_SREQ  = 4'd1,
    S_SWAIT = 4'd2,
    S_SEMIT = 4'd3,
    S_NL    = 4'd4,
    S_SBRK  = 4'd5,
    S_DONE  = 4'd6,
    S_HALT  = 4'd7
`ifdef SYSCALL_PRINT_INT_EN
    , S_PINT = 4'd8
`endif
  } state_t;

  state_t             r_state;
  logic [31:0]        r_arg;
  logic [29:0]        r_wptr;
  logic [1:0]         r_idx;
  logic [31:0]        r_word;
  logic [c_CNT_W-1:0] r_cnt;
  logic [31:0]        r_heap;
  logic               r_err;
`ifdef SYSCALL_PRINT_INT_EN
  logic [2:0]         r_nib;
  logic [3:0]         w_nib;
  logic [7:0]         w_hex;
`endif

  logic [7:0]  w_byte;
  logic        w_valid;
  logic [7:0]  w_data;
  logic [33:0] w_size;
  logic [33:0] w_sum;
  logic        w_fit;

  // Bytes are consumed big-endian: index 0 is the most significant byte.
  always_comb begin
    w_byte = 8'h00;
    case (r_idx)
      2'd0:    w_byte = r_word[31:24];
      2'd1:    w_byte = r_word[23:16];
      2'd2:    w_byte = r_word[15:8];
      default: w_byte = r_word[7:0];
    endcase
  end

`ifdef SYSCALL_PRINT_INT_EN
  always_comb begin
    w_nib = 4'h0;
    case (r_nib)
      3'd0:    w_nib = r_arg[31:28];
      3'd1:    w_nib = r_arg[27:24];
      3'd2:    w_nib = r_arg[23:20];
      3'd3:    w_nib = r_arg[19:16];
      3'd4:    w_nib = r_arg[15:12];
      3'd5:    w_nib = r_arg[11:8];
      3'd6:    w_nib = r_arg[7:4];
      default: w_nib = r_arg[3:0];
    endcase
    w_hex = (w_nib < 4'd10) ? (8'h30 + {4'h0, w_nib}) : (8'h57 + {4'h0, w_nib});
  end
`endif

  always_comb begin
    w_valid = 1'b0;
    w_data  = 8'h00;
    case (r_state)
      S_SEMIT: begin
        w_valid = (w_byte != 8'h00);
        w_data  = w_byte;
      end
      S_NL: begin
        w_valid = 1'b1;
        w_data  = 8'h0A;
      end
`ifdef SYSCALL_PRINT_INT_EN
      S_PINT: begin
        w_valid = 1'b1;
        w_data  = w_hex;
      end
`endif
      default: ;
    endcase
  end

  // Wide arithmetic so a huge a0 or a wrapping sum is rejected, never aliased.
  assign w_size = ({2'b00, r_arg} + 34'd3) & ~34'd3;
  assign w_sum  = {2'b00, r_heap} + w_size;
  assign w_fit  = (w_sum[33:32] == 2'b00) && (w_sum <= c_HEAP_END);

  assign bus.stall           = (r_state == S_IDLE && bus.syscall) ||
                               (r_state != S_IDLE && r_state != S_DONE);
  assign bus.rf_we           = (r_state == S_SBRK);
  assign bus.rf_wdata        = (r_state == S_SBRK) ? (w_fit ? r_heap : 32'hFFFF_FFFF) : 32'h0;
  assign bus.mem_req         = (r_state == S_SREQ);
  assign bus.mem_addr        = (r_state == S_SREQ) ? {r_wptr, 2'b00} : 32'h0;
  assign bus.out_valid       = w_valid;
  assign bus.out_data        = w_data;
  assign bus.heap_ptr        = r_heap;
  assign bus.halted          = (r_state == S_HALT);
  assign bus.err_unsupported = r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_arg   <= 32'h0;
      r_wptr  <= 30'h0;
      r_idx   <= 2'd0;
      r_word  <= 32'h0;
      r_cnt   <= '0;
      r_heap  <= HEAP_BASE;
      r_err   <= 1'b0;
`ifdef SYSCALL_PRINT_INT_EN
      r_nib   <= 3'd0;
`endif
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.syscall) begin
            r_arg <= bus.a0_data;
            case (bus.v0_data)
`ifdef SYSCALL_PRINT_INT_EN
              32'd1: begin
                r_nib   <= 3'd0;
                r_state <= S_PINT;
              end
`endif
              32'd4: begin
                r_wptr  <= bus.a0_data[31:2];
                r_idx   <= bus.a0_data[1:0];
                r_cnt   <= '0;
                r_state <= S_SREQ;
              end
              32'd9:   r_state <= S_SBRK;
              32'd10:  r_state <= S_HALT;
              default: begin
                r_err   <= 1'b1;
                r_state <= S_DONE;
              end
            endcase
          end
        end
`ifdef SYSCALL_PRINT_INT_EN
        S_PINT: begin
          if (bus.out_ready) begin
            r_nib <= r_nib + 3'd1;
            if (r_nib == 3'd7) r_state <= S_NL;
          end
        end
`endif
        S_SREQ:  r_state <= S_SWAIT;
        S_SWAIT: begin
          r_word  <= bus.mem_rdata;
          r_state <= S_SEMIT;
        end
        S_SEMIT: begin
          if (w_byte == 8'h00) begin
            r_state <= S_NL;
          end else if (bus.out_ready) begin
            r_cnt <= r_cnt + 1'b1;
            // The length cap wins over fetching the next word.
            if (r_cnt == c_LAST) begin
              r_state <= S_NL;
            end else if (r_idx == 2'd3) begin
              r_wptr  <= r_wptr + 30'd1;
              r_idx   <= 2'd0;
              r_state <= S_SREQ;
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end
        end
        S_NL: if (bus.out_ready) r_state <= S_DONE;
        S_SBRK: begin
          if (w_fit) r_heap <= w_sum[31:0];
          r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_syscall_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_syscall_engine : randomized self-checking bench for syscall_engine    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_syscall_engine;
  localparam logic [31:0] HEAP_BASE   = 32'h1000_0000;
  localparam logic [31:0] HEAP_BYTES  = 32'h0000_1000;
  localparam int          MAX_STR_LEN = 256;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] mem [128];
  longint unsigned model_heap;

  syscall_engine_if bus ();
  syscall_engine dut (.clk(clk), .reset(reset), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkstr(input string tag, input string obs, input string exp);
    int first = -1;
    for (int i = 0; i < exp.len() || i < obs.len(); i++)
      if (first < 0 && (i >= obs.len() || i >= exp.len() || obs[i] != exp[i])) first = i;
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed_len=%0d expected_len=%0d first_diff=%0d", tag, obs.len(), exp.len(), first);
    end
  endtask

  function automatic logic [7:0] mem_byte(input int addr);
    logic [31:0] w;
    w = mem[(addr >> 2) & 127];
    return w[8*(3 - (addr & 3)) +: 8];
  endfunction

  // Reference: walk byte-addressed memory until NUL or the length cap.
  task automatic str_model(input int a0, output string s, output int nreq);
    int addr = a0;
    int n = 0;
    bit stop = 0;
    s = "";
    while (!stop) begin
      if (mem_byte(addr) == 8'h00) stop = 1;
      else begin
        s = $sformatf("%s%c", s, mem_byte(addr));
        n++;
        if (n == MAX_STR_LEN) stop = 1;
        else addr++;
      end
    end
    nreq = (addr >> 2) - (a0 >> 2) + 1;
    s = $sformatf("%s\n", s);
  endtask

  task automatic sbrk_model(input logic [31:0] a0, output logic [31:0] wdata);
    longint unsigned size;
    size = ((longint'(a0) + 3) / 4) * 4;
    if (model_heap + size <= longint'(HEAP_BASE) + longint'(HEAP_BYTES)) begin
      wdata = model_heap[31:0];
      model_heap = model_heap + size;
    end else begin
      wdata = 32'hFFFF_FFFF;
    end
  endtask

  // Drives one syscall until the engine's release cycle and records what it did.
  task automatic run_call(input logic [31:0] v0, input logic [31:0] a0, input logic [3:0] rpat,
                          output string bytes, output int nreq, output int nwe,
                          output int nerr, output int nstall, output logic [31:0] wdata);
    int cyc = 0;
    bit done = 0;
    bit prev_hold = 0;
    logic [7:0] prev_data = 8'h00;
    bit pend = 0;
    logic [31:0] paddr = 32'h0;
    bytes = ""; nreq = 0; nwe = 0; nerr = 0; nstall = 0; wdata = 32'h0;
    @(posedge clk); #1;
    bus.v0_data = v0; bus.a0_data = a0; bus.syscall = 1'b1; bus.out_ready = rpat[3];
    while (!done && cyc < 3000) begin
      @(negedge clk);
      if (prev_hold) check32("hold_stable", {23'h0, bus.out_valid, bus.out_data}, {23'h0, 1'b1, prev_data});
      if (bus.err_unsupported) nerr++;
      if (bus.rf_we) begin nwe++; wdata = bus.rf_wdata; end
      if (bus.mem_req) begin nreq++; pend = 1; paddr = bus.mem_addr; end
      if (bus.out_valid && bus.out_ready) bytes = $sformatf("%s%c", bytes, bus.out_data);
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
      if (bus.stall === 1'b0) begin done = 1; bus.syscall = 1'b0; end
      else nstall++;
      @(posedge clk); #1;
      cyc++;
      bus.out_ready = rpat[3 - (cyc % 4)];
      if (pend) begin bus.mem_rdata = mem[paddr[8:2]]; pend = 0; end
    end
    bus.syscall = 1'b0;
    if (!done) check32("timeout", 32'(cyc), 32'(3000 + 1));
  endtask

  initial begin
    string s, exp_s;
    int nreq, nwe, nerr, nstall, exp_req;
    logic [31:0] wdata, exp_w, a0;
    int cyc;

    reset = 1'b1;
    bus.syscall = 1'b0; bus.v0_data = 32'h0; bus.a0_data = 32'h0;
    bus.mem_rdata = 32'h0; bus.out_ready = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check32("rst_heap", bus.heap_ptr, HEAP_BASE);
    check32("rst_flags", {26'h0, bus.stall, bus.rf_we, bus.mem_req, bus.out_valid, bus.halted, bus.err_unsupported}, 32'h0);
    check32("rst_buses", bus.rf_wdata | bus.mem_addr | {24'h0, bus.out_data}, 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    model_heap = HEAP_BASE;

    // sbrk directed
    run_call(32'd9, 32'd5, 4'hF, s, nreq, nwe, nerr, nstall, wdata);
    check32("sbrk5_wdata", wdata, 32'h1000_0000);
    check32("sbrk5_we", 32'(nwe), 32'd1);
    check32("sbrk5_stall", 32'(nstall), 32'd2);
    check32("sbrk5_heap", bus.heap_ptr, 32'h1000_0008);
    run_call(32'd9, 32'h1000, 4'hF, s, nreq, nwe, nerr, nstall, wdata);
    check32("sbrk_big_wdata", wdata, 32'hFFFF_FFFF);
    check32("sbrk_big_heap", bus.heap_ptr, 32'h1000_0008);
    model_heap = 64'h1000_0008;

    // string directed, free-running and throttled sink
    mem[0] = 32'h4142_4344; mem[1] = 32'h4500_4647;
    run_call(32'd4, 32'd2, 4'hF, s, nreq, nwe, nerr, nstall, wdata);
    checkstr("str_bytes", s, "CDE\n");
    check32("str_req", 32'(nreq), 32'd2);
    run_call(32'd4, 32'd2, 4'b1001, s, nreq, nwe, nerr, nstall, wdata);
    checkstr("str_throttle_bytes", s, "CDE\n");
    check32("str_throttle_req", 32'(nreq), 32'd2);

    // print integer
    run_call(32'd1, 32'h00C0_FFEE, 4'hF, s, nreq, nwe, nerr, nstall, wdata);
`ifdef SYSCALL_PRINT_INT_EN
    checkstr("pint_bytes", s, "00c0ffee\n");
    check32("pint_err", 32'(nerr), 32'd0);
`else
    checkstr("pint_bytes", s, "");
    check32("pint_err", 32'(nerr), 32'd1);
`endif
    for (int k = 0; k < 3; k++) begin
      a0 = $urandom;
      run_call(32'd1, a0, 4'($urandom_range(1, 15)), s, nreq, nwe, nerr, nstall, wdata);
`ifdef SYSCALL_PRINT_INT_EN
      checkstr("pint_rand", s, $sformatf("%08h\n", a0));
`else
      checkstr("pint_rand", s, "");
`endif
    end

    // unsupported code
    run_call(32'd7, 32'd0, 4'hF, s, nreq, nwe, nerr, nstall, wdata);
    check32("unsup_err", 32'(nerr), 32'd1);
    check32("unsup_stall", 32'(nstall), 32'd1);
    checkstr("unsup_bytes", s, "");
    for (int k = 0; k < 4; k++) begin
      exp_w = 32'($urandom_range(11, 1000));
      run_call(exp_w, $urandom, 4'hF, s, nreq, nwe, nerr, nstall, wdata);
      check32("unsup_rand_err", 32'(nerr + nwe + nreq), 32'd1);
    end

    // random sbrk against the heap model
    for (int k = 0; k < 25; k++) begin
      a0 = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 400));
      sbrk_model(a0, exp_w);
      run_call(32'd9, a0, 4'hF, s, nreq, nwe, nerr, nstall, wdata);
      check32("sbrk_rand_wdata", wdata, exp_w);
      check32("sbrk_rand_heap", bus.heap_ptr, model_heap[31:0]);
    end

    // random strings
    for (int k = 0; k < 6; k++) begin
      for (int w = 0; w < 128; w++)
        for (int b = 0; b < 4; b++)
          mem[w][8*b +: 8] = ($urandom_range(0, 11) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      a0 = 32'($urandom_range(0, 200));
      str_model(int'(a0), exp_s, exp_req);
      run_call(32'd4, a0, 4'($urandom_range(1, 15)), s, nreq, nwe, nerr, nstall, wdata);
      checkstr("str_rand_bytes", s, exp_s);
      check32("str_rand_req", 32'(nreq), 32'(exp_req));
    end

    // length cap
    for (int w = 0; w < 128; w++)
      for (int b = 0; b < 4; b++) mem[w][8*b +: 8] = 8'($urandom_range(1, 255));
    str_model(3, exp_s, exp_req);
    run_call(32'd4, 32'd3, 4'hF, s, nreq, nwe, nerr, nstall, wdata);
    checkstr("str_cap_bytes", s, exp_s);
    check32("str_cap_len", 32'(s.len()), 32'(MAX_STR_LEN + 1));
    check32("str_cap_req", 32'(nreq), 32'(exp_req));

    // reset while a byte is pending
    @(posedge clk); #1;
    bus.v0_data = 32'd4; bus.a0_data = 32'd0; bus.out_ready = 1'b0; bus.syscall = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (!bus.out_valid && cyc < 20) begin @(negedge clk); cyc++; end
    check32("midop_valid_seen", {31'h0, bus.out_valid}, 32'd1);
    reset = 1'b1; bus.syscall = 1'b0;
    @(negedge clk);
    check32("midop_valid_drop", {29'h0, bus.out_valid, bus.mem_req, bus.stall}, 32'd0);
    check32("midop_heap", bus.heap_ptr, HEAP_BASE);
    @(posedge clk); #1 reset = 1'b0;

    // exit then reset
    @(posedge clk); #1;
    bus.v0_data = 32'd10; bus.a0_data = 32'd0; bus.syscall = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (!bus.halted && cyc < 10) begin @(negedge clk); cyc++; end
    bus.syscall = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check32("halt_hold", {30'h0, bus.halted, bus.stall}, 32'd3);
    end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check32("halt_reset_flags", {30'h0, bus.halted, bus.stall}, 32'd0);
    check32("halt_reset_heap", bus.heap_ptr, HEAP_BASE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
